// File: rtl/freq_window_detector_if.sv
// Control/status bundle between the frequency window detector and its neighbours.
// The master side drives Enable/FB_Sig/Target and observes the frame verdict.
interface freq_window_detector_if #(
    parameter int CNT_W = 16
);
    logic             Enable;
    logic             FB_Sig;
    logic [CNT_W-1:0] Target;
    logic [7:0]       Time_Frame;
    logic             Slow;
    logic             Fast;
    logic             Lock;
    logic [CNT_W-1:0] Edge_Count;

    modport master (
        output Enable, FB_Sig, Target,
        input  Time_Frame, Slow, Fast, Lock, Edge_Count
    );

    modport slave (
        input  Enable, FB_Sig, Target,
        output Time_Frame, Slow, Fast, Lock, Edge_Count
    );
endinterface

// File: rtl/freq_window_detector.sv
// PLL frequency comparator: counts feedback rising edges in a per-frame window,
// compares against Target once per frame, and reports Slow/Fast/Lock.
module freq_window_detector #(
    parameter int FRAME_LEN = 64,
    parameter int MEAS_LEN  = 28,
    parameter int TOL       = 1,
    parameter int LOCK_CNT  = 4,
    parameter int CNT_W     = 16
) (
    input logic                   REF_Clk,
    input logic                   Reset_n,
    freq_window_detector_if.slave bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_COMPARE, ST_HOLD} state_t;

    localparam int               RUN_W     = $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W:0]   TOL_X     = (CNT_W + 1)'(TOL);
    localparam logic [7:0]       MEAS_SLOT = 8'(MEAS_LEN);
    localparam logic [7:0]       LAST_SLOT = 8'(FRAME_LEN - 1);

    state_t           state_q, state_n, cur_state;
    logic [7:0]       tf_q, tf_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] ec_q, ec_n;
    logic [RUN_W-1:0] run_q, run_n, run_inc;
    logic             slow_q, slow_n, fast_q, fast_n, lock_q, lock_n;
    logic             fb_d, fb_edge;
    logic [1:0]       vd;

    function automatic state_t slot_state(input logic [7:0] slot);
        if (slot < MEAS_SLOT)
            return ST_MEASURE;
        else if (slot == MEAS_SLOT)
            return ST_COMPARE;
        else
            return ST_HOLD;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

    function automatic logic [RUN_W-1:0] sat_run(input logic [RUN_W-1:0] run);
        return (run == RUN_MAX) ? run : run + 1'b1;
    endfunction

    // One extra bit of headroom so count+TOL and Target+TOL cannot wrap.
    function automatic logic [1:0] band_verdict(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] tgt);
        logic [CNT_W:0] cnt_x;
        logic [CNT_W:0] tgt_x;
        cnt_x = {1'b0, cnt};
        tgt_x = {1'b0, tgt};
        return {(cnt_x + TOL_X) < tgt_x, cnt_x > (tgt_x + TOL_X)};
    endfunction

    assign fb_edge   = bus.FB_Sig & ~fb_d;
    assign run_inc   = sat_run(run_q);
    // IDLE always parks Time_Frame at 0, so the resumed frame acts as that slot.
    assign cur_state = (state_q == ST_IDLE) ? slot_state(tf_q) : state_q;

    always_comb begin
        state_n = state_q;
        tf_n    = tf_q;
        cnt_n   = cnt_q;
        ec_n    = ec_q;
        run_n   = run_q;
        slow_n  = slow_q;
        fast_n  = fast_q;
        lock_n  = lock_q;
        vd      = 2'b00;
        if (!bus.Enable) begin
            state_n = ST_IDLE;
            tf_n    = 8'd0;
            cnt_n   = '0;
            run_n   = '0;
            slow_n  = 1'b0;
            fast_n  = 1'b0;
            lock_n  = 1'b0;
        end else begin
            tf_n    = (tf_q == LAST_SLOT) ? 8'd0 : tf_q + 8'd1;
            state_n = slot_state(tf_n);
            case (cur_state)
                ST_MEASURE: begin
                    if (fb_edge)
                        cnt_n = sat_inc(cnt_q);
                end
                ST_COMPARE: begin
                    vd     = band_verdict(cnt_q, bus.Target);
                    ec_n   = cnt_q;
                    cnt_n  = '0;
                    slow_n = vd[1];
                    fast_n = vd[0];
                    if (vd == 2'b00) begin
                        run_n  = run_inc;
                        lock_n = (run_inc == RUN_MAX);
                    end else begin
                        run_n  = '0;
                        lock_n = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge REF_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            tf_q    <= 8'd0;
            cnt_q   <= '0;
            ec_q    <= '0;
            run_q   <= '0;
            slow_q  <= 1'b0;
            fast_q  <= 1'b0;
            lock_q  <= 1'b0;
            fb_d    <= 1'b0;
        end else begin
            state_q <= state_n;
            tf_q    <= tf_n;
            cnt_q   <= cnt_n;
            ec_q    <= ec_n;
            run_q   <= run_n;
            slow_q  <= slow_n;
            fast_q  <= fast_n;
            lock_q  <= lock_n;
            fb_d    <= bus.FB_Sig;
        end
    end

    assign bus.Time_Frame = tf_q;
    assign bus.Slow       = slow_q;
    assign bus.Fast       = fast_q;
    assign bus.Lock       = lock_q;
    assign bus.Edge_Count = ec_q;

endmodule

// File: tb/tb_freq_window_detector.sv
// Frame-level randomized bench for freq_window_detector: a wide-counter instance and a
// 3-bit-counter instance share stimulus; expectations flow through scoreboard queues.
module tb_freq_window_detector;

    localparam int FRAME_LEN = 64;
    localparam int MEAS_LEN  = 28;
    localparam int TOL       = 1;
    localparam int LOCK_CNT  = 4;
    localparam int CNT_W     = 16;
    localparam int CNT_WS    = 3;
    localparam int CMAX_M    = (1 << CNT_W) - 1;
    localparam int CMAX_S    = (1 << CNT_WS) - 1;

    typedef struct {
        int ec;
        int slow;
        int fast;
        int lock;
    } exp_t;

    logic REF_Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 REF_Clk = ~REF_Clk;

    freq_window_detector_if #(.CNT_W(CNT_W))  bus ();
    freq_window_detector_if #(.CNT_W(CNT_WS)) bus_s ();

    freq_window_detector #(
        .FRAME_LEN(FRAME_LEN), .MEAS_LEN(MEAS_LEN), .TOL(TOL),
        .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)
    ) dut (
        .REF_Clk(REF_Clk), .Reset_n(Reset_n), .bus(bus)
    );

    freq_window_detector #(
        .FRAME_LEN(FRAME_LEN), .MEAS_LEN(MEAS_LEN), .TOL(TOL),
        .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_WS)
    ) dut_s (
        .REF_Clk(REF_Clk), .Reset_n(Reset_n), .bus(bus_s)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q_m[$];
    exp_t q_s[$];

    // Frame-level reference state
    int prev_fb = 0;
    int run_m = 0, run_s = 0;
    int held_m = 0, held_s = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, req);
        end
    endtask

    task automatic drive(input bit en, input bit fb);
        bus.Enable   = en;
        bus_s.Enable = en;
        bus.FB_Sig   = fb;
        bus_s.FB_Sig = fb;
    endtask

    task automatic model_cmp(input int edges, input int cmax, input int tgt,
                             inout int run, inout int held, output exp_t e);
        e.ec   = (edges > cmax) ? cmax : edges;
        e.slow = int'(e.ec + TOL < tgt);
        e.fast = int'(e.ec > tgt + TOL);
        if (e.slow == 0 && e.fast == 0) begin
            if (run < LOCK_CNT) run++;
            e.lock = int'(run == LOCK_CNT);
        end else begin
            run    = 0;
            e.lock = 0;
        end
        held = e.ec;
    endtask

    // kind 0: periodic (per/hi/ph), 1: random bits, 2: held low.
    // Negative targets are picked relative to the frame's true edge count.
    task automatic run_frame(input int kind, input int per, input int hi, input int ph,
                             input int tgt_a, input int tgt_b, input int tgt_s,
                             input int stop_at, input bit do_rst);
        bit   fb[FRAME_LEN];
        int   edges, p;
        exp_t e;
        for (int s = 0; s < FRAME_LEN; s++) begin
            case (kind)
                0:       fb[s] = ((s + ph) % per) < hi;
                1:       fb[s] = 1'($urandom_range(0, 1));
                default: fb[s] = 1'b0;
            endcase
        end
        edges = 0;
        p = prev_fb;
        for (int s = 0; s < MEAS_LEN; s++) begin
            if (fb[s] && p == 0) edges++;
            p = int'(fb[s]);
        end
        if (tgt_a < 0) tgt_a = $urandom_range(0, 40);
        if (tgt_b < 0) begin
            tgt_b = edges + $urandom_range(0, 6) - 3;
            if (tgt_b < 0) tgt_b = 0;
        end
        if (tgt_s < 0) tgt_s = $urandom_range(0, CMAX_S);
        if (do_rst ? (stop_at > MEAS_LEN + 1) : (stop_at > MEAS_LEN)) begin
            model_cmp(edges, CMAX_M, tgt_b, run_m, held_m, e);
            q_m.push_back(e);
            model_cmp(edges, CMAX_S, tgt_s, run_s, held_s, e);
            q_s.push_back(e);
        end
        for (int s = 0; s < stop_at; s++) begin
            drive(1'b1, fb[s]);
            bus.Target   = (s < 10) ? CNT_W'(tgt_a) : CNT_W'(tgt_b);
            bus_s.Target = CNT_WS'(tgt_s);
            @(posedge REF_Clk);
            #1;
        end
        if (stop_at > 0) prev_fb = int'(fb[stop_at - 1]);
        if (do_rst) begin
            drive(1'b1, fb[stop_at]);
            #2 Reset_n = 1'b0;
            #1;
            chk("rst_tf",       int'(bus.Time_Frame),   0);
            chk("rst_slow",     int'(bus.Slow),         0);
            chk("rst_fast",     int'(bus.Fast),         0);
            chk("rst_lock",     int'(bus.Lock),         0);
            chk("rst_ec",       int'(bus.Edge_Count),   0);
            chk("rst_s_lock",   int'(bus_s.Lock),       0);
            chk("rst_s_ec",     int'(bus_s.Edge_Count), 0);
            #2 Reset_n = 1'b1;
            run_m = 0; run_s = 0; held_m = 0; held_s = 0; prev_fb = 0;
        end
    endtask

    task automatic idle(input int n);
        exp_t e;
        bit   fb;
        for (int i = 0; i < n; i++) begin
            run_m = 0;
            run_s = 0;
            e.ec = held_m; e.slow = 0; e.fast = 0; e.lock = 0;
            q_m.push_back(e);
            e.ec = held_s;
            q_s.push_back(e);
            fb = 1'($urandom_range(0, 1));
            drive(1'b0, fb);
            @(posedge REF_Clk);
            #1;
            prev_fb = int'(fb);
        end
    endtask

    // Monitor: consumes an expectation whenever the DUT presents a verdict or an idle cycle.
    initial begin : monitor
        exp_t em, es, last_m, last_s;
        bit   en_s, rs_s, have_last;
        have_last = 1'b0;
        forever begin
            @(posedge REF_Clk);
            en_s = bus.Enable;
            rs_s = Reset_n;
            @(negedge REF_Clk);
            if (rs_s && (!en_s || int'(bus.Time_Frame) == MEAS_LEN + 1)) begin
                chk("pending_expect", int'(q_m.size() > 0 && q_s.size() > 0), 1);
                if (q_m.size() > 0 && q_s.size() > 0) begin
                    em = q_m.pop_front();
                    es = q_s.pop_front();
                    if (!en_s) begin
                        chk("idle_tf",   int'(bus.Time_Frame),   0);
                        chk("idle_s_tf", int'(bus_s.Time_Frame), 0);
                    end else begin
                        last_m = em;
                        last_s = es;
                        have_last = 1'b1;
                    end
                    chk("ec",     int'(bus.Edge_Count),   em.ec);
                    chk("slow",   int'(bus.Slow),         em.slow);
                    chk("fast",   int'(bus.Fast),         em.fast);
                    chk("lock",   int'(bus.Lock),         em.lock);
                    chk("s_ec",   int'(bus_s.Edge_Count), es.ec);
                    chk("s_slow", int'(bus_s.Slow),       es.slow);
                    chk("s_fast", int'(bus_s.Fast),       es.fast);
                    chk("s_lock", int'(bus_s.Lock),       es.lock);
                end
            end else if (rs_s && have_last && int'(bus.Time_Frame) == FRAME_LEN - 1) begin
                chk("hold_ec",   int'(bus.Edge_Count), last_m.ec);
                chk("hold_slow", int'(bus.Slow),       last_m.slow);
                chk("hold_fast", int'(bus.Fast),       last_m.fast);
                chk("hold_lock", int'(bus.Lock),       last_m.lock);
                chk("hold_s_ec", int'(bus_s.Edge_Count), last_s.ec);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int kind, per, stop;
        drive(1'b0, 1'b0);
        bus.Target   = '0;
        bus_s.Target = '0;
        repeat (3) @(posedge REF_Clk);
        #1;
        chk("reset_tf",   int'(bus.Time_Frame),   0);
        chk("reset_slow", int'(bus.Slow),         0);
        chk("reset_fast", int'(bus.Fast),         0);
        chk("reset_lock", int'(bus.Lock),         0);
        chk("reset_ec",   int'(bus.Edge_Count),   0);
        chk("reset_s_ec", int'(bus_s.Edge_Count), 0);
        Reset_n = 1'b1;

        // Period 4 in band until Lock, one period-8 frame drops it, two more in band
        repeat (4) run_frame(0, 4, 2, 0, 7, 7, 7, FRAME_LEN, 1'b0);
        run_frame(0, 8, 4, 0, 7, 7, 7, FRAME_LEN, 1'b0);
        repeat (2) run_frame(0, 4, 2, 0, 7, 7, 7, FRAME_LEN, 1'b0);
        // Toggling feedback: fast, then a mid-frame Target change takes effect at compare
        run_frame(0, 2, 1, 0, 7, 7, 0, FRAME_LEN, 1'b0);
        run_frame(0, 2, 1, 0, 7, 14, 7, FRAME_LEN, 1'b0);
        repeat (3) run_frame(0, 4, 2, 0, 7, 7, 7, FRAME_LEN, 1'b0);
        // Asynchronous reset at slot 40 while locked
        run_frame(0, 4, 2, 0, 7, 7, 7, 40, 1'b1);
        run_frame(0, 4, 2, 0, 7, 7, 7, FRAME_LEN, 1'b0);
        // Enable dropped at slot 15, then Target 0 with quiet feedback
        run_frame(0, 4, 2, 0, 7, 7, 7, 15, 1'b0);
        idle(3);
        run_frame(2, 1, 0, 0, 0, 0, 0, FRAME_LEN, 1'b0);

        for (int f = 0; f < 30; f++) begin
            kind = $urandom_range(0, 2);
            per  = $urandom_range(2, 9);
            stop = FRAME_LEN;
            if ($urandom_range(0, 5) == 0) stop = $urandom_range(1, FRAME_LEN - 1);
            if (stop < FRAME_LEN && $urandom_range(0, 1) == 0) begin
                run_frame(kind, per, $urandom_range(1, per - 1), $urandom_range(0, per - 1),
                          -1, -1, -1, stop, 1'b1);
            end else begin
                run_frame(kind, per, $urandom_range(1, per - 1), $urandom_range(0, per - 1),
                          -1, -1, -1, stop, 1'b0);
                if (stop < FRAME_LEN) idle($urandom_range(1, 3));
            end
        end

        repeat (2) @(posedge REF_Clk);
        #1;
        chk("scoreboard_drained", q_m.size() + q_s.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
